// File: rtl/gpio_seg_scan.sv
// gpio_seg_scan: time-multiplexed scanner for an 8-digit, active-low 7-segment display.
// Each digit is lit for DIV cycles, followed by BLANK dark cycles. The segment patterns
// are copied into shadow registers once per frame, so a frame never mixes old and new data.
//
// Ports:
//   clock          - sole clock; all state changes on its rising edge
//   reset          - asynchronous, active-high reset
//   seg_in_0..7    - per-digit segment patterns (from the GPIO segment registers)
//   enable         - scan enable; 0 forces the display dark and returns to idle
//   seg_out        - segment lines, active-low, bit 7 = decimal point (registered)
//   an_n           - digit anode selects, active-low, bit k = digit k (registered)
//   frame_done     - one-cycle pulse when idx wraps 7->0 (registered)
module gpio_seg_scan #(
    parameter int unsigned DIV   = 1000,
    parameter int unsigned BLANK = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] seg_in_0,
    input  logic [7:0] seg_in_1,
    input  logic [7:0] seg_in_2,
    input  logic [7:0] seg_in_3,
    input  logic [7:0] seg_in_4,
    input  logic [7:0] seg_in_5,
    input  logic [7:0] seg_in_6,
    input  logic [7:0] seg_in_7,
    input  logic       enable,
    output logic [7:0] seg_out,
    output logic [7:0] an_n,
    output logic       frame_done
);

    typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

    localparam logic [15:0] DivLast   = 16'(DIV - 1);
    localparam logic [15:0] BlankLast = (BLANK > 0) ? 16'(BLANK - 1) : 16'd0;
    localparam bit          NoGap     = (BLANK == 0);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  sh_q [8];
    logic [7:0]  sh_d [8];
    logic [7:0]  seg_in_w [8];
    logic [7:0]  seg_d, an_d;
    logic        wrap, load;

    assign seg_in_w[0] = seg_in_0;
    assign seg_in_w[1] = seg_in_1;
    assign seg_in_w[2] = seg_in_2;
    assign seg_in_w[3] = seg_in_3;
    assign seg_in_w[4] = seg_in_4;
    assign seg_in_w[5] = seg_in_5;
    assign seg_in_w[6] = seg_in_6;
    assign seg_in_w[7] = seg_in_7;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        wrap    = 1'b0;
        load    = 1'b0;

        if (!enable) begin
            state_d = StIdle;
            idx_d   = 3'd0;
            cnt_d   = 16'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StShow;
                    idx_d   = 3'd0;
                    cnt_d   = 16'd0;
                    load    = 1'b1;
                end
                StShow: begin
                    if (cnt_q == DivLast) begin
                        cnt_d = 16'd0;
                        if (NoGap) begin
                            // Back-to-back digits: advance without a dark phase.
                            idx_d = idx_q + 3'd1;
                            wrap  = (idx_q == 3'd7);
                            load  = wrap;
                        end else begin
                            state_d = StGap;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StGap: begin
                    if (cnt_q == BlankLast) begin
                        cnt_d   = 16'd0;
                        idx_d   = idx_q + 3'd1;
                        wrap    = (idx_q == 3'd7);
                        load    = wrap;
                        state_d = StShow;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = 3'd0;
                    cnt_d   = 16'd0;
                end
            endcase
        end

        if (load) begin
            sh_d = seg_in_w;
        end

        // Outputs are registered from the next state so they track the state being entered.
        if (state_d == StShow) begin
            an_d  = ~(8'h01 << idx_d);
            seg_d = sh_d[idx_d];
        end else begin
            an_d  = 8'hFF;
            seg_d = 8'hFF;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= 3'd0;
            cnt_q      <= 16'd0;
            for (int k = 0; k < 8; k++) begin
                sh_q[k] <= 8'hFF;
            end
            an_n       <= 8'hFF;
            seg_out    <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            an_n       <= an_d;
            seg_out    <= seg_d;
            frame_done <= wrap;
        end
    end

endmodule
